// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the keypad scanner that sits in the CPU keyboard
// window at base address 0xFFFFFC10.
//   - Register byte offsets inside the window (DATA, STATUS, CONTROL).
//   - CONTROL register bit positions.
//   - Scanner FSM state encoding.
// ---------------------------------------------------------------------------
package kbd_pkg;

    // Byte offsets inside the keyboard window.
    localparam logic [2:0] KBD_DATA   = 3'h0;
    localparam logic [2:0] KBD_STATUS = 3'h2;
    localparam logic [2:0] KBD_CTRL   = 3'h4;

    // CONTROL bit positions. Only irq_en is stored; the other two are
    // write-1 pulses and always read back as 0.
    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_FLUSH   = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        SCAN     = 3'd2,
        PUSH     = 3'd3,
        RELEASE  = 3'd4
    } kbd_state_t;

endpackage

// File: rtl/keypad_scan_fifo_if.sv
// ---------------------------------------------------------------------------
// keypad_scan_fifo_if
// CPU I/O bus as seen by the keyboard window.
//   read_enable       read strobe, one cycle per access
//   write_enable      write strobe, one cycle per access
//   address           byte offset inside the window
//   write_data        write data
//   read_data_output  read data, combinational from address while strobed
//   interrupt         level interrupt request
// Handshake: there is no ready/valid pair. Every access is a single-cycle
// strobe that the peripheral always accepts; a read returns its data in the
// same cycle and any side effect (FIFO pop) takes place on the closing edge.
// ---------------------------------------------------------------------------
interface keypad_scan_fifo_if;
    logic        read_enable;
    logic        write_enable;
    logic [2:0]  address;
    logic [15:0] write_data;
    logic [15:0] read_data_output;
    logic        interrupt;

    modport master (
        output read_enable, write_enable, address, write_data,
        input  read_data_output, interrupt
    );

    modport slave (
        input  read_enable, write_enable, address, write_data,
        output read_data_output, interrupt
    );
endinterface

// File: rtl/key_fifo.sv
// ---------------------------------------------------------------------------
// key_fifo
// Small synchronous FIFO for key codes with combinational head output.
//   clock, reset  system clock, asynchronous active-high reset
//   push, din     write request and data (ignored when full unless popping)
//   pop           read request (ignored when empty)
//   flush         empties the FIFO; overrides a simultaneous push
//   dout          head entry (valid when !empty)
//   empty, full   status flags
//   count         number of stored entries
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate counter.
// ---------------------------------------------------------------------------
module key_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // When full, a push is still accepted if the head leaves on the same
    // edge: the new entry lands in the slot that is being vacated.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/keypad_scan_fifo.sv
// ---------------------------------------------------------------------------
// keypad_scan_fifo
// ROWS x COLS matrix keypad scanner with press/release debounce, a key-code
// FIFO and a bus register window.
//   clock, reset   system clock, asynchronous active-high reset
//   bus            CPU I/O bus (slave side): DATA / STATUS / CONTROL
//   column         keypad columns, active-low, already synchronised
//   row            keypad row drive, active-low
//   fsm_state      current scanner state, for observation
// Code of a key = row_index * COLS + column_index.
// ---------------------------------------------------------------------------
module keypad_scan_fifo
    import kbd_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clock,
    input  logic               reset,
    keypad_scan_fifo_if.slave  bus,
    input  logic [COLS-1:0]    column,
    output logic [ROWS-1:0]    row,
    output kbd_state_t         fsm_state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    kbd_state_t      state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [RW-1:0]   r, r_next;
    logic            settle, settle_next;   // 1 on the sampling cycle of a row
    logic [7:0]      code, code_next;

    logic            any_low;
    logic [7:0]      col_idx;
    logic            fifo_push;

    logic            fifo_pop;
    logic            fifo_flush;
    logic [7:0]      fifo_dout;
    logic            fifo_empty;
    logic            fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [3:0]      count_lo;

    logic            irq_en;
    logic            overflow;
    logic            ctrl_wr;
    logic            clr_ovf;
    logic            overflow_set;

    assign fsm_state = state;
    assign any_low   = ~&column;

    // Priority encoder: lowest-index low column wins when several keys of
    // the same row are down.
    always_comb begin
        col_idx = 8'd0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!column[c]) col_idx = 8'(c);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            r      <= '0;
            settle <= 1'b0;
            code   <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            r      <= r_next;
            settle <= settle_next;
            code   <= code_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        r_next      = r;
        settle_next = settle;
        code_next   = code;
        case (state)
            IDLE: begin
                if (any_low) begin
                    state_next = DEBOUNCE;
                    cnt_next   = '0;
                end
            end
            DEBOUNCE: begin
                if (!any_low) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next  = SCAN;
                    r_next      = '0;
                    settle_next = 1'b0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SCAN: begin
                // First cycle of a row lets the lines settle; second samples.
                if (!settle) begin
                    settle_next = 1'b1;
                end else begin
                    settle_next = 1'b0;
                    if (any_low) begin
                        code_next  = 8'(32'(r) * COLS + 32'(col_idx));
                        state_next = PUSH;
                    end else if (r == ROW_LAST) begin
                        // Key vanished before its row was reached.
                        state_next = IDLE;
                    end else begin
                        r_next = r + 1'b1;
                    end
                end
            end
            PUSH: begin
                state_next = RELEASE;
                cnt_next   = '0;
            end
            RELEASE: begin
                // Every key must be up for the full window; any low column
                // restarts it, so a held key never produces a second code.
                if (any_low) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        row       = '0;
        fifo_push = 1'b0;
        case (state)
            SCAN:    row = ~(ROWS'(1) << r);
            PUSH:    fifo_push = 1'b1;
            default: ;
        endcase
    end

    // ---------------- FIFO ----------------
    assign ctrl_wr    = bus.write_enable && (bus.address == KBD_CTRL);
    assign fifo_flush = ctrl_wr && bus.write_data[CTRL_FLUSH];
    assign clr_ovf    = ctrl_wr && bus.write_data[CTRL_CLR_OVF];
    assign fifo_pop   = bus.read_enable && (bus.address == KBD_DATA) && !fifo_empty;

    key_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (code),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // A code is lost only when it arrives at a full FIFO that is neither
    // draining nor being flushed on the same edge.
    assign overflow_set = fifo_push && fifo_full && !fifo_pop && !fifo_flush;
    assign count_lo     = 4'(fifo_count);

    // ---------------- control / status registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= bus.write_data[CTRL_IRQ_EN];
            // A new overflow takes priority over a clear on the same edge.
            if (overflow_set)  overflow <= 1'b1;
            else if (clr_ovf)  overflow <= 1'b0;
        end
    end

    logic unused_write_bits;
    assign unused_write_bits = ^bus.write_data[15:3];

    always_comb begin
        bus.read_data_output = 16'd0;
        if (bus.read_enable) begin
            case (bus.address)
                KBD_DATA:   bus.read_data_output = fifo_empty ? 16'd0 : {8'd0, fifo_dout};
                KBD_STATUS: bus.read_data_output = {8'd0, count_lo, 1'b0, overflow,
                                                    fifo_full, ~fifo_empty};
                KBD_CTRL:   bus.read_data_output = {15'd0, irq_en};
                default:    bus.read_data_output = 16'd0;
            endcase
        end
    end

    assign bus.interrupt = irq_en & ~fifo_empty;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
module tb_keypad_scan_fifo;
    import kbd_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DC   = 8;
    localparam int DEPTH = 4;

    logic              clock;
    logic              reset;
    logic [COLS-1:0]   column;
    logic [ROWS-1:0]   row;
    kbd_state_t        fsm_state;
    logic [ROWS*COLS-1:0] keys;

    int check_count = 0;
    int error_count = 0;
    logic [7:0] exp_q[$];

    keypad_scan_fifo_if bus_if ();

    keypad_scan_fifo #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .DEBOUNCE_CYCLES (DC),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_if),
        .column    (column),
        .row       (row),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        column = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int rr = 0; rr < ROWS; rr++) begin
                if (keys[rr*COLS + c] && !row[rr]) column[c] = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clock);
        bus_if.read_enable = 1'b1;
        bus_if.address     = a;
        #1 d = bus_if.read_data_output;
        @(negedge clock);
        bus_if.read_enable = 1'b0;
        bus_if.address     = 3'd0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clock);
        bus_if.write_enable = 1'b1;
        bus_if.address      = a;
        bus_if.write_data   = d;
        @(negedge clock);
        bus_if.write_enable = 1'b0;
        bus_if.address      = 3'd0;
        bus_if.write_data   = 16'd0;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [15:0] exp, input string tag);
        logic [15:0] d;
        bus_read(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic read_data_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            read_check(KBD_DATA, {8'd0, e}, tag);
        end
    endtask

    task automatic wait_state(input kbd_state_t target, input int budget, input string tag);
        int n = 0;
        while (fsm_state != target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(fsm_state), 32'(target));
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        @(negedge clock);
        keys[r*COLS + c] = v;
    endtask

    // Full press/release cycle of one key; code is the hand-computed code.
    task automatic do_key(input int r, input int c, input logic [7:0] code,
                          input logic expect_stored, input string tag);
        if (expect_stored) exp_q.push_back(code);
        set_key(r, c, 1'b1);
        wait_state(RELEASE, 200, {tag, "_to_release"});
        set_key(r, c, 1'b0);
        wait_state(IDLE, 200, {tag, "_to_idle"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] d;
        keys                = '0;
        bus_if.read_enable  = 1'b0;
        bus_if.write_enable = 1'b0;
        bus_if.address      = 3'd0;
        bus_if.write_data   = 16'd0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_row", 32'(row), 32'h0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        check("reset_irq", 32'(bus_if.interrupt), 32'd0);
        check("reset_rdata_idle", 32'(bus_if.read_data_output), 32'd0);
        reset = 1'b0;
        read_check(KBD_STATUS, 16'h0000, "reset_status");

        // 1. Single key r2,c1 -> code 9, pushed once while held.
        exp_q.push_back(8'd9);
        set_key(2, 1, 1'b1);
        wait_state(RELEASE, 200, "t1_to_release");
        repeat (40) @(negedge clock);
        check("t1_held_state", 32'(fsm_state), 32'(RELEASE));
        read_check(KBD_STATUS, 16'h0011, "t1_status_one");
        check("t1_irq_masked", 32'(bus_if.interrupt), 32'd0);
        read_data_check("t1_data");
        read_check(KBD_STATUS, 16'h0000, "t1_status_after");
        set_key(2, 1, 1'b0);
        wait_state(IDLE, 200, "t1_to_idle");

        // 2. Glitch shorter than the debounce window.
        set_key(1, 1, 1'b1);
        repeat (2) @(negedge clock);
        check("t2_debounce", 32'(fsm_state), 32'(DEBOUNCE));
        repeat (3) @(negedge clock);
        keys = '0;
        repeat (3) @(negedge clock);
        check("t2_idle", 32'(fsm_state), 32'(IDLE));
        check("t2_irq", 32'(bus_if.interrupt), 32'd0);
        read_check(KBD_STATUS, 16'h0000, "t2_status");

        // 3. irq enabled, five presses, no reads: fifth is lost.
        bus_write(KBD_CTRL, 16'h0001);
        read_check(KBD_CTRL, 16'h0001, "t3_ctrl");
        do_key(0, 0, 8'd0, 1'b1, "t3_k0");
        check("t3_irq_first", 32'(bus_if.interrupt), 32'd1);
        do_key(1, 2, 8'd6, 1'b1, "t3_k1");
        do_key(3, 3, 8'd15, 1'b1, "t3_k2");
        do_key(2, 0, 8'd8, 1'b1, "t3_k3");
        read_check(KBD_STATUS, 16'h0047 & 16'hFFFB, "t3_status_full_no_ovf");
        do_key(0, 3, 8'd3, 1'b0, "t3_k4");
        read_check(KBD_STATUS, 16'h0047, "t3_status_ovf");
        check("t3_irq", 32'(bus_if.interrupt), 32'd1);

        // 4. Full FIFO, DATA read in the PUSH cycle of code 5.
        exp_q.push_back(8'd5);
        set_key(1, 1, 1'b1);
        wait_state(PUSH, 200, "t4_to_push");
        bus_if.read_enable = 1'b1;
        bus_if.address     = KBD_DATA;
        #1 d = bus_if.read_data_output;
        check("t4_oldest", 32'(d), {24'd0, exp_q.pop_front()});
        @(negedge clock);
        bus_if.read_enable = 1'b0;
        wait_state(RELEASE, 20, "t4_to_release");
        set_key(1, 1, 1'b0);
        wait_state(IDLE, 200, "t4_to_idle");
        read_check(KBD_STATUS, 16'h0047, "t4_status_count4");
        read_data_check("t4_d6");
        read_data_check("t4_d15");
        read_data_check("t4_d8");
        read_data_check("t4_d5_newest");
        read_check(KBD_STATUS, 16'h0004, "t4_status_empty_ovf");
        read_check(KBD_DATA, 16'h0000, "t4_data_empty");
        bus_write(KBD_CTRL, 16'h0003);
        read_check(KBD_STATUS, 16'h0000, "t4_ovf_cleared");
        read_check(KBD_CTRL, 16'h0001, "t4_ctrl_readback");
        check("t4_irq_empty", 32'(bus_if.interrupt), 32'd0);

        // 5. Two keys in row 0 (cols 1 and 3): lowest column wins.
        exp_q.push_back(8'd1);
        @(negedge clock);
        keys[0*COLS + 1] = 1'b1;
        keys[0*COLS + 3] = 1'b1;
        wait_state(RELEASE, 200, "t5_to_release");
        set_key(0, 1, 1'b0);
        repeat (3*DC) @(negedge clock);
        check("t5_still_release", 32'(fsm_state), 32'(RELEASE));
        set_key(0, 3, 1'b0);
        wait_state(IDLE, 200, "t5_to_idle");
        read_check(KBD_STATUS, 16'h0011, "t5_status_one");
        read_data_check("t5_code1");

        // 6. Reset during SCAN with a code pending and irq enabled.
        do_key(2, 3, 8'd11, 1'b1, "t6_pre");
        check("t6_irq_pending", 32'(bus_if.interrupt), 32'd1);
        set_key(3, 2, 1'b1);
        wait_state(SCAN, 200, "t6_to_scan");
        check("t6_scan_row0", 32'(row), 32'hE);
        reset = 1'b1;
        #1;
        check("t6_rst_row", 32'(row), 32'h0);
        check("t6_rst_irq", 32'(bus_if.interrupt), 32'd0);
        check("t6_rst_state", 32'(fsm_state), 32'(IDLE));
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        read_check(KBD_STATUS, 16'h0000, "t6_status_after_rst");
        read_check(KBD_CTRL, 16'h0000, "t6_ctrl_after_rst");
        exp_q.push_back(8'd14);
        wait_state(RELEASE, 200, "t6_rescan");
        read_data_check("t6_code14");
        set_key(3, 2, 1'b0);
        wait_state(IDLE, 200, "t6_to_idle");

        // 7. Flush, write-1 bits reading 0, unmapped offset.
        do_key(0, 2, 8'd2, 1'b0, "t7_k0");
        do_key(1, 3, 8'd7, 1'b0, "t7_k1");
        read_check(KBD_STATUS, 16'h0021, "t7_status_two");
        bus_write(KBD_CTRL, 16'h0007);
        read_check(KBD_STATUS, 16'h0000, "t7_flushed");
        read_check(KBD_CTRL, 16'h0001, "t7_ctrl_pulse_bits");
        check("t7_irq", 32'(bus_if.interrupt), 32'd0);
        read_check(3'h6, 16'h0000, "t7_unmapped");

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
